legv8_alc_pipe: RTL and testbench

Parametrised, registered successor to the LEGv8 ALU control decoder. Translates the 2-bit `ALUOp` from main control plus the instruction opcode into an ALU control word, covering R-type and I-type arithmetic/logic/shift ops. Results flow through a valid/ready output stage with illegal-opcode flagging and an optional multi-cycle MUL stall. Sits between the decode stage and the ALU/execute stage.

---
 rtl/legv8_alc_pipe.sv | 149 ++++++++++++++
 tb/tb_legv8_alc_pipe.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/legv8_alc_pipe.sv
// LEGv8 ALU control decoder with a registered valid/ready output stage.
// Optional feature macro: LEGV8_ALC_MUL_EN enables MUL decode (1100) and the
// MULW multi-cycle stall; without it MUL is flagged illegal and busy is tied 0.
module legv8_alc_pipe #(
    parameter int unsigned CTRL_W  = 4,
    parameter int unsigned MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [10:0]       op_code,
    input  logic [1:0]        ALUOp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ALU_ctrl,
    output logic              illegal,
    output logic              busy
);

    typedef enum logic [1:0] {StEmpty, StHold, StMulw} state_e;

    // Elaboration-time sanity checks on the parameters.
    if (CTRL_W < 4) begin : g_bad_ctrl_w
        $error("CTRL_W must be at least 4");
    end
    if (MUL_LAT < 2 || MUL_LAT > 16) begin : g_bad_mul_lat
        $error("MUL_LAT must be in 2..16");
    end

    state_e     state_q, state_d;
    logic [3:0] ctrl_q, ctrl_d;
    logic       illegal_q, illegal_d;
    logic [3:0] dec_ctrl;
    logic       dec_illegal;
    logic       dec_mul;
    logic       accept;

`ifdef LEGV8_ALC_MUL_EN
    // Counts remaining MULW cycles; loaded so HOLD is reached MUL_LAT cycles after accept.
    localparam logic [4:0] MulLoad = 5'(MUL_LAT - 2);
    logic [4:0] cnt_q, cnt_d;
`endif

    // Decode ALUOp/op_code into the 4-bit control code, illegal flag and MUL marker.
    always_comb begin
        dec_ctrl    = 4'b1111;
        dec_illegal = 1'b1;
        dec_mul     = 1'b0;
        unique case (ALUOp)
            2'b00: begin dec_ctrl = 4'b0010; dec_illegal = 1'b0; end
            2'b01: begin dec_ctrl = 4'b0111; dec_illegal = 1'b0; end
            2'b10: begin
                case (op_code)
                    11'b10001011000: begin dec_ctrl = 4'b0010; dec_illegal = 1'b0; end
                    11'b11001011000: begin dec_ctrl = 4'b0110; dec_illegal = 1'b0; end
                    11'b10001010000: begin dec_ctrl = 4'b0000; dec_illegal = 1'b0; end
                    11'b10101010000: begin dec_ctrl = 4'b0001; dec_illegal = 1'b0; end
                    11'b11001010000: begin dec_ctrl = 4'b0011; dec_illegal = 1'b0; end
                    11'b11010011011: begin dec_ctrl = 4'b1000; dec_illegal = 1'b0; end
                    11'b11010011010: begin dec_ctrl = 4'b1001; dec_illegal = 1'b0; end
`ifdef LEGV8_ALC_MUL_EN
                    11'b10011011000: begin
                        dec_ctrl    = 4'b1100;
                        dec_illegal = 1'b0;
                        dec_mul     = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            default: begin
                case (op_code[10:1])
                    10'b1001000100: begin dec_ctrl = 4'b0010; dec_illegal = 1'b0; end
                    10'b1101000100: begin dec_ctrl = 4'b0110; dec_illegal = 1'b0; end
                    10'b1001001000: begin dec_ctrl = 4'b0000; dec_illegal = 1'b0; end
                    10'b1011001000: begin dec_ctrl = 4'b0001; dec_illegal = 1'b0; end
                    10'b1101001000: begin dec_ctrl = 4'b0011; dec_illegal = 1'b0; end
                    default: ;
                endcase
            end
        endcase
    end

    assign in_ready  = (state_q == StEmpty) || ((state_q == StHold) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == StHold);
    assign ALU_ctrl  = CTRL_W'(ctrl_q);
    assign illegal   = illegal_q;
`ifdef LEGV8_ALC_MUL_EN
    assign busy      = (state_q == StMulw);
`else
    assign busy      = 1'b0;
`endif

    // Next-state logic: load on accept, drain on out_ready, count down through MULW.
    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
`ifdef LEGV8_ALC_MUL_EN
        cnt_d     = cnt_q;
`endif
        if (accept) begin
            ctrl_d    = dec_ctrl;
            illegal_d = dec_illegal;
            state_d   = dec_mul ? StMulw : StHold;
`ifdef LEGV8_ALC_MUL_EN
            cnt_d     = dec_mul ? MulLoad : 5'd0;
`endif
        end else begin
            unique case (state_q)
                StHold: if (out_ready) state_d = StEmpty;
                StMulw: begin
`ifdef LEGV8_ALC_MUL_EN
                    if (cnt_q == 5'd0) begin
                        state_d = StHold;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
`else
                    state_d = StEmpty;
`endif
                end
                default: ;
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StEmpty;
            ctrl_q    <= 4'b0000;
            illegal_q <= 1'b0;
`ifdef LEGV8_ALC_MUL_EN
            cnt_q     <= 5'd0;
`endif
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
`ifdef LEGV8_ALC_MUL_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_legv8_alc_pipe.sv
// Directed scoreboard bench for legv8_alc_pipe (MUL_LAT=4).
module tb_legv8_alc_pipe;

    localparam int unsigned CtrlW = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [10:0]      op_code;
    logic [1:0]       ALUOp;
    logic             out_valid;
    logic             out_ready;
    logic [CtrlW-1:0] ALU_ctrl;
    logic             illegal;
    logic             busy;

    int vectors = 0;
    int miscompares = 0;
    logic [4:0] sb_q[$];

    legv8_alc_pipe #(.CTRL_W(CtrlW), .MUL_LAT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_code   (op_code),
        .ALUOp     (ALUOp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALU_ctrl  (ALU_ctrl),
        .illegal   (illegal),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference decode: {illegal, ctrl}.
    function automatic logic [4:0] model(input logic [1:0] a, input logic [10:0] o);
        logic [9:0] hi;
        hi = o[10:1];
        if (a == 2'b00) return 5'b0_0010;
        if (a == 2'b01) return 5'b0_0111;
        if (a == 2'b10) begin
            if (o == 11'b10001011000) return 5'b0_0010;
            if (o == 11'b11001011000) return 5'b0_0110;
            if (o == 11'b10001010000) return 5'b0_0000;
            if (o == 11'b10101010000) return 5'b0_0001;
            if (o == 11'b11001010000) return 5'b0_0011;
            if (o == 11'b11010011011) return 5'b0_1000;
            if (o == 11'b11010011010) return 5'b0_1001;
`ifdef LEGV8_ALC_MUL_EN
            if (o == 11'b10011011000) return 5'b0_1100;
`endif
            return 5'b1_1111;
        end
        if (hi == 10'b1001000100) return 5'b0_0010;
        if (hi == 10'b1101000100) return 5'b0_0110;
        if (hi == 10'b1001001000) return 5'b0_0000;
        if (hi == 10'b1011001000) return 5'b0_0001;
        if (hi == 10'b1101001000) return 5'b0_0011;
        return 5'b1_1111;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, sample at negedge (optional checks, scoreboard), advance.
    // eov/ebusy/eir: 0 or 1 to check, -1 to skip.
    task automatic step(input logic v, input logic [1:0] a, input logic [10:0] o,
                        input logic r, input int eov, input int ebusy, input int eir);
        logic [4:0] exp;
        in_valid  = v;
        ALUOp     = a;
        op_code   = o;
        out_ready = r;
        @(negedge clk);
        if (eov >= 0)   chk("out_valid", 32'(out_valid), 32'(eov));
        if (ebusy >= 0) chk("busy", 32'(busy), 32'(ebusy));
        if (eir >= 0)   chk("in_ready", 32'(in_ready), 32'(eir));
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", 32'(1), 32'(0));
            end else begin
                exp = sb_q.pop_front();
                chk("ALU_ctrl", 32'(ALU_ctrl), 32'(exp[3:0]));
                chk("illegal", 32'(illegal), 32'(exp[4]));
            end
        end
        if (in_valid && in_ready) sb_q.push_back(model(a, o));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int eov);
        step(1'b0, 2'b00, 11'd0, 1'b1, eov, -1, -1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_ALU_ctrl"}, 32'(ALU_ctrl), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Asynchronous reset pulse between clock edges, then discard pending results.
    task automatic mid_reset(input string tag);
        #1 rst_n = 1'b0;
        #1 check_reset_vals(tag);
        sb_q.delete();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_code   = '0;
        ALUOp     = '0;
        out_ready = 1'b0;
        #2 check_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Decode sweep, streamed with out_ready=1.
        step(1'b1, 2'b10, 11'b10001011000, 1'b1, -1, -1, 1);
        step(1'b1, 2'b10, 11'b11001011000, 1'b1, 1, -1, 1);
        step(1'b1, 2'b10, 11'b10001010000, 1'b1, 1, -1, 1);
        step(1'b1, 2'b10, 11'b10101010000, 1'b1, 1, -1, 1);
        step(1'b1, 2'b10, 11'b11001010000, 1'b1, 1, -1, 1);
        step(1'b1, 2'b10, 11'b11010011011, 1'b1, 1, -1, 1);
        step(1'b1, 2'b10, 11'b11010011010, 1'b1, 1, -1, 1);
        step(1'b1, 2'b11, {10'b1001000100, 1'($urandom)}, 1'b1, 1, -1, 1);
        step(1'b1, 2'b11, {10'b1101000100, 1'($urandom)}, 1'b1, 1, -1, 1);
        step(1'b1, 2'b11, {10'b1001001000, 1'($urandom)}, 1'b1, 1, -1, 1);
        step(1'b1, 2'b11, {10'b1011001000, 1'($urandom)}, 1'b1, 1, -1, 1);
        step(1'b1, 2'b11, {10'b1101001000, 1'($urandom)}, 1'b1, 1, -1, 1);
        step(1'b1, 2'b00, 11'($urandom), 1'b1, 1, -1, 1);
        step(1'b1, 2'b01, 11'($urandom), 1'b1, 1, -1, 1);
        step(1'b1, 2'b10, 11'b11111111111, 1'b1, 1, -1, 1);
        step(1'b1, 2'b11, 11'b00000000001, 1'b1, 1, -1, 1);
        idle(1);
        idle(0);

        // Streaming: no bubbles across four back-to-back ops.
        step(1'b1, 2'b10, 11'b10001011000, 1'b1, 0, -1, 1);
        step(1'b1, 2'b10, 11'b11001011000, 1'b1, 1, -1, 1);
        step(1'b1, 2'b11, 11'b10110010000, 1'b1, 1, -1, 1);
        step(1'b1, 2'b10, 11'b11010011010, 1'b1, 1, -1, 1);
        idle(1);
        idle(0);

        // Backpressure: AND held for three stalled cycles while EOR waits.
        step(1'b1, 2'b10, 11'b10001010000, 1'b1, 0, -1, 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b10, 11'b11001010000, 1'b0, 1, -1, 0);
            chk("bp_hold_ctrl", 32'(ALU_ctrl), 32'b0000);
        end
        step(1'b1, 2'b10, 11'b11001010000, 1'b1, 1, -1, 1);
        idle(1);
        idle(0);

        // Reset mid-stream while an output is pending.
        step(1'b1, 2'b10, 11'b11001011000, 1'b0, -1, -1, 1);
        step(1'b0, 2'b00, 11'd0, 1'b0, 1, -1, 0);
        mid_reset("mid");
        idle(0);

`ifdef LEGV8_ALC_MUL_EN
        // MUL: busy N+1..N+3, result at N+4, then a following ADD accepted at N+4.
        step(1'b1, 2'b10, 11'b10011011000, 1'b1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 11'b10001011000, 1'b1, 0, 1, 0);
        step(1'b1, 2'b10, 11'b10001011000, 1'b1, 1, 0, 1);
        idle(1);
        idle(0);
        // Reset pulse at N+2 discards the MUL.
        step(1'b1, 2'b10, 11'b10011011000, 1'b1, 0, 0, 1);
        step(1'b0, 2'b00, 11'd0, 1'b1, 0, 1, 0);
        mid_reset("mulrst");
        for (int i = 0; i < 5; i++) step(1'b0, 2'b00, 11'd0, 1'b1, 0, 0, 1);
`else
        // MUL without the feature: illegal on the 1-cycle path, never busy.
        step(1'b1, 2'b10, 11'b10011011000, 1'b1, 0, 0, 1);
        step(1'b0, 2'b00, 11'd0, 1'b1, 1, 0, 1);
        for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 11'd0, 1'b1, 0, 0, 1);
`endif

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
